// File: rtl/bootrom_arbiter_pkg.sv
// Shared state type and line-address helpers for the boot-ROM fetch arbiter.
package bootrom_arb_pkg;

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_e;

    function automatic int lw_of(input int blen);
        return $clog2(blen);
    endfunction

    // Step the word field of a byte address, wrapping inside an aligned 2**lw-word line.
    function automatic logic [31:0] wrap_inc(input logic [31:0] pc, input int lw);
        logic [31:0] mask;
        mask = ((32'd1 << lw) - 32'd1) << 2;
        return (pc & ~mask) | ((pc + 32'd4) & mask);
    endfunction

endpackage

// File: rtl/bootrom_arbiter_if.sv
// Requester-side bus of the boot-ROM arbiter: burst requests in, beats out.
interface bootrom_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16
);
    import bootrom_arb_pkg::*;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] adr;
    logic [NREQ-1:0]    ack;
    logic               last;
    logic [31:0]        dat_o;
    logic               busy;
    logic [2:0]         gnt_id;

    modport master (output req, adr, input ack, last, dat_o, busy, gnt_id);
    modport slave  (input req, adr, output ack, last, dat_o, busy, gnt_id);

endinterface

// File: rtl/bootrom_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req at or after ptr+1, wrapping.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic            any,
    output logic [2:0]      g
);
    int w_dist;
    int w_best;

    // Smallest circular distance past ptr wins; ptr itself is farthest.
    always_comb begin
        g      = '0;
        w_best = NREQ;
        w_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + 2 * NREQ - int'(ptr) - 1) % NREQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                g      = 3'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter sharing one boot-ROM read port; critical-word-first line bursts.
module bootrom_arbiter
    import bootrom_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 16,
    parameter int BLEN    = 4,
    parameter int ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    bootrom_arbiter_if.slave bus,
    output logic [AW-1:0]    rom_pc,
    input  logic [31:0]      rom_insn
);
    localparam int LW = lw_of(BLEN);
    localparam int CW = $clog2(ROM_LAT + 1);

    state_e          r_state, w_nxt_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_beat, r_ptr, r_gnt;
    logic [AW-1:0]   r_pc;
    logic [31:0]     r_dat;
    logic [NREQ-1:0] r_ack;
    logic            r_last, r_busy;

    logic            w_any, w_fire, w_done;
    logic [2:0]      w_g;
    logic [AW-1:0]   w_start;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (bus.req),
        .ptr (r_ptr),
        .any (w_any),
        .g   (w_g)
    );

    always_comb begin
        w_start = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_g == 3'(i)) w_start = bus.adr[i*AW +: AW];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_fire      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: if (w_any) w_nxt_state = READ;
            READ: begin
                w_fire = (r_cnt == CW'(1));
                w_done = w_fire && (r_beat == 3'(BLEN - 1));
                if (w_done) w_nxt_state = IDLE;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_beat <= '0;
            r_ptr  <= 3'(NREQ - 1);
            r_gnt  <= '0;
            r_pc   <= '0;
            r_dat  <= '0;
            r_ack  <= '0;
            r_last <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_last <= 1'b0;
            if (r_state == IDLE) begin
                if (w_any) begin
                    r_gnt  <= w_g;
                    r_ptr  <= w_g;
                    r_pc   <= w_start & ~AW'(3);
                    r_beat <= '0;
                    r_cnt  <= CW'(ROM_LAT);
                    r_busy <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt - CW'(1);
                if (w_fire) begin
                    r_dat  <= rom_insn;
                    r_ack  <= NREQ'(1) << r_gnt;
                    r_beat <= r_beat + 3'd1;
                    if (w_done) begin
                        r_last <= 1'b1;
                        r_busy <= 1'b0;
                    end else begin
                        r_pc  <= AW'(wrap_inc(32'(r_pc), LW));
                        r_cnt <= CW'(ROM_LAT);
                    end
                end
            end
        end
    end

    assign bus.ack    = r_ack;
    assign bus.last   = r_last;
    assign bus.dat_o  = r_dat;
    assign bus.busy   = r_busy;
    assign bus.gnt_id = r_gnt;
    assign rom_pc     = r_pc;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Bench for bootrom_arbiter: one default instance plus a ROM_LAT=3/BLEN=2 instance.
module tb_bootrom_arbiter;
    localparam int NREQ  = 4;
    localparam int AW    = 16;
    localparam int BLEN  = 4;
    localparam int BBLEN = 2;

    typedef struct {
        int          id;
        logic [31:0] dat;
        logic        last;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bootrom_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();
    bootrom_arbiter_if #(.NREQ(2), .AW(AW))    bbus ();

    logic [AW-1:0] rom_pc, brom_pc;
    logic [31:0]   rom_insn, brom_insn, bp0, bp1;

    logic [NREQ-1:0] want = '0, keep = '0, hold = '0, clr = '0;
    logic [1:0]      bwant = '0, bclr = '0;
    logic [AW-1:0]   adrs [NREQ];
    logic [AW-1:0]   badr = '0;
    beat_t           beats[$], bbeats[$];
    int              checks = 0, fails = 0, cyc = 0;

    // Requesters drop req in the ack&last cycle unless told to hold it.
    assign bus.req  = want & ~(bus.ack & {NREQ{bus.last}} & ~hold);
    assign bus.adr  = {adrs[3], adrs[2], adrs[1], adrs[0]};
    assign bbus.req = bwant & ~(bbus.ack & {2{bbus.last}});
    assign bbus.adr = {badr, badr};

    // ROM word n holds n; the slow ROM delays its data by two extra edges.
    assign rom_insn = {18'd0, rom_pc[AW-1:2]};
    always @(posedge clk) begin
        bp0 <= {18'd0, brom_pc[AW-1:2]};
        bp1 <= bp0;
    end
    assign brom_insn = bp1;

    bootrom_arbiter #(.NREQ(NREQ), .AW(AW), .BLEN(BLEN), .ROM_LAT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .rom_pc(rom_pc), .rom_insn(rom_insn)
    );

    bootrom_arbiter #(.NREQ(2), .AW(AW), .BLEN(BBLEN), .ROM_LAT(3)) dut_slow (
        .clk(clk), .rst(rst), .bus(bbus), .rom_pc(brom_pc), .rom_insn(brom_insn)
    );

    function automatic logic [31:0] exp_word(input logic [AW-1:0] a, input int k, input int blen);
        int w;
        w = int'(a) / 4;
        return 32'((w / blen) * blen + ((w % blen) + k) % blen);
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        want  = want & ~clr;
        bwant = bwant & ~bclr;
        clr   = '0;
        bclr  = '0;
        if (rst && bus.ack != '0) begin
            checks++;
            if (bus.ack !== (NREQ'(1) << bus.gnt_id)) begin
                fails++;
                $display("FAIL ack_grantee ack=%b gnt_id=%0d", bus.ack, bus.gnt_id);
            end
            beats.push_back('{int'(bus.gnt_id), bus.dat_o, bus.last, cyc});
            clr = bus.ack & {NREQ{bus.last}} & ~keep;
        end
        if (rst && bbus.ack != '0) begin
            bbeats.push_back('{int'(bbus.gnt_id), bbus.dat_o, bbus.last, cyc});
            bclr = bbus.ack & {2{bbus.last}};
        end
    endtask

    task automatic wait_beats(input int n, output bit to);
        int c;
        c = 0;
        while (beats.size() < n && c < 200) begin
            tick();
            c++;
        end
        to = (beats.size() < n);
    endtask

    task automatic apply_reset(input logic [NREQ-1:0] w0);
        rst = 1'b0;
        want = w0; keep = '0; hold = '0; clr = '0; bwant = '0; bclr = '0;
        tick();
        tick();
        rst = 1'b1;
        beats.delete();
        bbeats.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; want = '1; bwant = 2'b11;
        for (int i = 0; i < NREQ; i++) adrs[i] = AW'($urandom);
        tick();
        tick();
        checks++; if (bus.ack !== '0)   begin fails++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
        checks++; if (bus.last !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", bus.last); end
        checks++; if (bus.dat_o !== '0) begin fails++; $display("FAIL reset_dat got=%h exp=0", bus.dat_o); end
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.gnt_id !== '0) begin fails++; $display("FAIL reset_gnt got=%0d exp=0", bus.gnt_id); end
        checks++; if (rom_pc !== '0)     begin fails++; $display("FAIL reset_pc got=%h exp=0", rom_pc); end
        checks++; if (bbus.busy !== 1'b0) begin fails++; $display("FAIL reset_slow_busy got=%b exp=0", bbus.busy); end
        want = '0; bwant = '0; rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [AW-1:0] pcs  [4] = '{16'h0108, 16'h010C, 16'h0100, 16'h0104};
        logic [31:0]   dats [4] = '{32'h42, 32'h43, 32'h40, 32'h41};
        int c;
        c = 0;
        adrs[0] = 16'h0108;
        want[0] = 1'b1;
        while (!bus.busy && c < 10) begin tick(); c++; end
        checks++;
        if (bus.busy !== 1'b1 || bus.gnt_id !== 3'd0) begin
            fails++; $display("FAIL single_grant busy=%b gnt_id=%0d exp busy=1 gnt_id=0", bus.busy, bus.gnt_id);
        end
        for (int j = 0; j <= 4; j++) begin
            if (j < 4) begin
                checks++;
                if (rom_pc !== pcs[j]) begin fails++; $display("FAIL single_pc beat=%0d got=%h exp=%h", j, rom_pc, pcs[j]); end
            end
            if (j > 0) begin
                checks++;
                if (bus.ack !== NREQ'(1) || bus.dat_o !== dats[j-1] || bus.last !== (j == 4)) begin
                    fails++;
                    $display("FAIL single_beat beat=%0d ack=%b dat=%h last=%b exp ack=0001 dat=%h last=%b",
                             j - 1, bus.ack, bus.dat_o, bus.last, dats[j-1], (j == 4));
                end
            end
            if (j < 4) tick();
        end
        tick();
        beats.delete();
    endtask

    task automatic test_contention();
        bit to;
        for (int i = 0; i < NREQ; i++) adrs[i] = AW'($urandom);
        apply_reset('1);
        wait_beats(4 * BLEN, to);
        checks++;
        if (to) begin fails++; $display("FAIL contention_timeout beats=%0d exp=%0d", beats.size(), 4 * BLEN); end
        else for (int b = 0; b < 4; b++) for (int k = 0; k < BLEN; k++) begin
            checks++;
            if (beats[b*BLEN+k].id != b || beats[b*BLEN+k].dat !== exp_word(adrs[b], k, BLEN) ||
                beats[b*BLEN+k].last !== (k == BLEN - 1)) begin
                fails++;
                $display("FAIL contention_beat n=%0d id=%0d dat=%h last=%b exp id=%0d dat=%h", b*BLEN+k,
                         beats[b*BLEN+k].id, beats[b*BLEN+k].dat, beats[b*BLEN+k].last, b, exp_word(adrs[b], k, BLEN));
            end
        end
        tick();
        beats.delete();
        adrs[0] = AW'($urandom);
        adrs[2] = AW'($urandom);
        want = 4'b0101;
        wait_beats(2 * BLEN, to);
        checks++;
        if (to || beats[0].id != 0 || beats[BLEN].id != 2) begin
            fails++; $display("FAIL contention_reraise timeout=%0d first=%0d second=%0d exp 0 then 2", to, beats[0].id, beats[BLEN].id);
        end
        tick();
        beats.delete();
    endtask

    task automatic test_fairness();
        bit to;
        int c;
        apply_reset('0);
        adrs[1] = AW'($urandom);
        adrs[3] = AW'($urandom);
        keep = 4'b1010;
        want = 4'b1010;
        wait_beats(4 * BLEN, to);
        keep = '0;
        checks++;
        if (to) begin fails++; $display("FAIL fair_timeout beats=%0d exp=%0d", beats.size(), 4 * BLEN); end
        else for (int n = 0; n < 4 * BLEN; n++) begin
            checks++;
            if (beats[n].id != (((n / BLEN) % 2 == 1) ? 3 : 1)) begin
                fails++; $display("FAIL fair_order beat=%0d got=%0d exp=%0d", n, beats[n].id, ((n / BLEN) % 2 == 1) ? 3 : 1);
            end
        end
        c = 0;
        while ((want != '0 || bus.busy) && c < 200) begin tick(); c++; end
        checks++;
        if (want != '0 || bus.busy) begin fails++; $display("FAIL fair_drain want=%b busy=%b exp 0/0", want, bus.busy); end
        tick();
        beats.delete();
    endtask

    task automatic test_held();
        bit to;
        beats.delete();
        adrs[2] = AW'($urandom);
        want[2] = 1'b1; keep[2] = 1'b1; hold[2] = 1'b1;
        wait_beats(BLEN, to);
        checks++;
        if (to || bus.busy !== 1'b0 || bus.last !== 1'b1) begin
            fails++; $display("FAIL held_gap timeout=%0d busy=%b last=%b exp busy=0 last=1", to, bus.busy, bus.last);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.gnt_id !== 3'd2) begin
            fails++; $display("FAIL held_regrant busy=%b gnt_id=%0d exp busy=1 gnt_id=2", bus.busy, bus.gnt_id);
        end
        keep = '0; hold = '0;
        wait_beats(2 * BLEN, to);
        checks++;
        if (to || beats[BLEN].id != 2 || beats[BLEN].dat !== exp_word(adrs[2], 0, BLEN)) begin
            fails++; $display("FAIL held_second timeout=%0d id=%0d dat=%h exp id=2 dat=%h",
                              to, beats[BLEN].id, beats[BLEN].dat, exp_word(adrs[2], 0, BLEN));
        end
        tick();
        beats.delete();
    endtask

    task automatic test_reset_mid();
        bit to;
        apply_reset('0);
        adrs[2] = AW'($urandom);
        want = 4'b0100;
        wait_beats(1, to);
        rst = 1'b0; want = '0; clr = '0;
        #1;
        checks++;
        if (to || bus.ack !== '0 || bus.busy !== 1'b0 || rom_pc !== '0 || bus.gnt_id !== '0) begin
            fails++; $display("FAIL midreset_abort timeout=%0d ack=%b busy=%b pc=%h gnt=%0d exp all 0",
                              to, bus.ack, bus.busy, rom_pc, bus.gnt_id);
        end
        adrs[1] = AW'($urandom);
        adrs[3] = AW'($urandom);
        want = 4'b1010;
        tick();
        checks++;
        if (bus.ack !== '0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL midreset_hold ack=%b busy=%b exp 0/0", bus.ack, bus.busy);
        end
        rst = 1'b1;
        beats.delete();
        wait_beats(2 * BLEN, to);
        checks++;
        if (to || beats[0].id != 1 || beats[BLEN].id != 3) begin
            fails++; $display("FAIL midreset_order timeout=%0d first=%0d second=%0d exp 1 then 3", to, beats[0].id, beats[BLEN].id);
        end
        tick();
        beats.delete();
    endtask

    task automatic test_latency();
        int c, c0;
        bbeats.delete();
        badr  = 16'h00FC;
        bwant = 2'b01;
        c = 0;
        while (!bbus.busy && c < 10) begin tick(); c++; end
        c0 = cyc;
        c = 0;
        while (bbeats.size() < 2 && c < 50) begin tick(); c++; end
        checks++;
        if (bbeats.size() < 2) begin fails++; $display("FAIL lat_timeout beats=%0d exp=2", bbeats.size()); end
        else for (int k = 0; k < BBLEN; k++) begin
            checks++;
            if (bbeats[k].cyc != c0 + 3 * (k + 1) || bbeats[k].dat !== exp_word(badr, k, BBLEN) ||
                bbeats[k].last !== (k == BBLEN - 1) || bbeats[k].id != 0) begin
                fails++; $display("FAIL lat_beat k=%0d cyc=%0d dat=%h last=%b exp cyc=%0d dat=%h", k,
                                  bbeats[k].cyc - c0, bbeats[k].dat, bbeats[k].last, 3 * (k + 1), exp_word(badr, k, BBLEN));
            end
        end
        tick();
        bbeats.delete();
    endtask

    task automatic test_random();
        bit to;
        int mptr, n;
        int ord[$];
        logic [NREQ-1:0] m;
        apply_reset('0);
        mptr = NREQ - 1;
        for (int r = 0; r < 6; r++) begin
            ord.delete();
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) if (m[i]) adrs[i] = AW'($urandom);
            for (int k = 1; k <= NREQ; k++) if (m[(mptr + k) % NREQ]) ord.push_back((mptr + k) % NREQ);
            want = m;
            wait_beats(ord.size() * BLEN, to);
            checks++;
            if (to) begin fails++; $display("FAIL rand_timeout round=%0d beats=%0d exp=%0d", r, beats.size(), ord.size() * BLEN); end
            else for (int b = 0; b < ord.size(); b++) for (int k = 0; k < BLEN; k++) begin
                n = b * BLEN + k;
                checks++;
                if (beats[n].id != ord[b] || beats[n].dat !== exp_word(adrs[ord[b]], k, BLEN) ||
                    beats[n].last !== (k == BLEN - 1)) begin
                    fails++; $display("FAIL rand_beat round=%0d n=%0d id=%0d dat=%h last=%b exp id=%0d dat=%h", r, n,
                                      beats[n].id, beats[n].dat, beats[n].last, ord[b], exp_word(adrs[ord[b]], k, BLEN));
                end
            end
            mptr = ord[ord.size() - 1];
            tick();
            beats.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) adrs[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_held();
        test_reset_mid();
        test_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
